// File: rtl/dsp_file_responder.sv
// rtl/dsp_file_responder.sv - request/response front end for NUM_FILES independent circular word FIFOs
// One request at a time runs IDLE -> ACCESS -> RESP; FIFO state moves only at the end of ACCESS.
module dsp_file_responder #(
   parameter int dw        = 32,
   parameter int NUM_FILES = 4,
   parameter int DEPTH     = 16
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst,
   input  logic [7:0]           file_num,
   input  logic                 file_write,
   input  logic                 file_read,
   input  logic [dw-1:0]        file_write_data,
   output logic [dw-1:0]        file_read_data,
   output logic                 file_active,
   output logic                 file_error,
   output logic [NUM_FILES-1:0] file_empty,
   output logic [NUM_FILES-1:0] file_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int FW = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [7:0]           r_num;
   logic                 r_wr;
   logic                 r_rd;
   logic [dw-1:0]        r_wdata;
   logic                 r_fail;
   logic                 r_error;
   logic [dw-1:0]        r_rdata;
   logic [NUM_FILES-1:0] r_empty;
   logic [NUM_FILES-1:0] r_full;
   logic [AW-1:0]        r_wptr  [NUM_FILES];
   logic [AW-1:0]        r_rptr  [NUM_FILES];
   logic [CW-1:0]        r_count [NUM_FILES];
   logic [dw-1:0]        r_mem   [NUM_FILES][DEPTH];

   logic          w_valid_num;
   logic [FW-1:0] w_idx;
   logic [AW-1:0] w_wptr;
   logic [AW-1:0] w_rptr;
   logic [CW-1:0] w_cnt;
   logic          w_do_push;
   logic          w_do_pop;
   logic          w_fail;
   logic          w_req;

   assign w_req = file_read | file_write;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_req) w_next = S_ACCESS;
         S_ACCESS: w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Out-of-range selectors never touch the arrays: push/pop are gated by w_valid_num.
   assign w_valid_num = (int'(r_num) < NUM_FILES);
   assign w_idx       = r_num[FW-1:0];
   assign w_wptr      = r_wptr[w_idx];
   assign w_rptr      = r_rptr[w_idx];
   assign w_cnt       = r_count[w_idx];

   always_comb begin
      w_do_push = 1'b0;
      w_do_pop  = 1'b0;
      if (r_state == S_ACCESS && w_valid_num) begin
         w_do_push = r_wr && !r_rd && !r_full[w_idx];
         w_do_pop  = r_rd && !r_wr && !r_empty[w_idx];
      end
      w_fail = !(w_do_push || w_do_pop);
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         r_state <= S_IDLE;
         r_num   <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_wdata <= '0;
         r_fail  <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= '0;
         r_empty <= '1;
         r_full  <= '0;
         for (int i = 0; i < NUM_FILES; i++) begin
            r_wptr[i]  <= '0;
            r_rptr[i]  <= '0;
            r_count[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_error <= 1'b0;
         if (r_state == S_IDLE && w_req) begin
            r_num   <= file_num;
            r_wr    <= file_write;
            r_rd    <= file_read;
            r_wdata <= file_write_data;
         end
         if (r_state == S_ACCESS) r_fail <= w_fail;
         // Error pulse lands on the cycle file_active drops.
         if (r_state == S_RESP) r_error <= r_fail;
         if (w_do_push) begin
            r_wptr[w_idx]  <= w_wptr + AW'(1);
            r_count[w_idx] <= w_cnt + CW'(1);
            r_empty[w_idx] <= 1'b0;
            r_full[w_idx]  <= (w_cnt == CNT_LAST);
         end
         if (w_do_pop) begin
            r_rptr[w_idx]  <= w_rptr + AW'(1);
            r_count[w_idx] <= w_cnt - CW'(1);
            r_full[w_idx]  <= 1'b0;
            r_empty[w_idx] <= (w_cnt == CNT_ONE);
            r_rdata        <= r_mem[w_idx][w_rptr];
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (w_do_push) r_mem[w_idx][w_wptr] <= r_wdata;
   end

   assign file_active    = (r_state != S_IDLE);
   assign file_error     = r_error;
   assign file_read_data = r_rdata;
   assign file_empty     = r_empty;
   assign file_full      = r_full;

endmodule

// File: tb/tb_dsp_file_responder.sv
// tb/tb_dsp_file_responder.sv - scoreboard bench for dsp_file_responder against a queue-based file model
module tb_dsp_file_responder;

   localparam int NF = 4;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    file_num = '0;
   logic          file_write = 1'b0;
   logic          file_read = 1'b0;
   logic [31:0]   file_write_data = '0;
   logic [31:0]   file_read_data;
   logic          file_active;
   logic          file_error;
   logic [NF-1:0] file_empty;
   logic [NF-1:0] file_full;

   dsp_file_responder #(.dw(32), .NUM_FILES(NF), .DEPTH(DP)) dut (
      .wb_clk          (clk),
      .wb_rst          (rst),
      .file_num        (file_num),
      .file_write      (file_write),
      .file_read       (file_read),
      .file_write_data (file_write_data),
      .file_read_data  (file_read_data),
      .file_active     (file_active),
      .file_error      (file_error),
      .file_empty      (file_empty),
      .file_full       (file_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          err;
      logic [31:0]   rdata;
      logic [NF-1:0] empty;
      logic [NF-1:0] full;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mq[NF][$];
   logic [31:0] m_rdata = '0;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model_step(input bit rd, input bit wr, input logic [7:0] num,
                                       input logic [31:0] d);
      exp_t e;
      bit   fail;
      fail = 1'b0;
      if (num >= NF || (rd && wr)) fail = 1'b1;
      else if (wr && mq[num].size() == DP) fail = 1'b1;
      else if (rd && mq[num].size() == 0) fail = 1'b1;
      if (!fail) begin
         if (wr) mq[num].push_back(d);
         else m_rdata = mq[num].pop_front();
      end
      e.err   = fail;
      e.rdata = m_rdata;
      for (int f = 0; f < NF; f++) begin
         e.empty[f] = (mq[f].size() == 0);
         e.full[f]  = (mq[f].size() == DP);
      end
      return e;
   endfunction

   // Called just after a falling edge; returns on the falling edge where the response is visible.
   task automatic issue(input bit rd, input bit wr, input logic [7:0] num, input logic [31:0] d,
                        input bit glitch);
      exp_q.push_back(model_step(rd, wr, num, d));
      file_read = rd;
      file_write = wr;
      file_num = num;
      file_write_data = d;
      @(negedge clk);
      file_read = 1'b0;
      file_write = glitch;
      if (glitch) begin
         file_num = 8'($urandom_range(0, NF - 1));
         file_write_data = $urandom;
      end
      @(negedge clk);
      file_write = 1'b0;
      @(negedge clk);
   endtask

   int act_len = 0;
   bit prev_act = 1'b0;
   bit chk_clear = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         act_len = 0;
         prev_act = 1'b0;
         chk_clear = 1'b0;
      end else begin
         if (chk_clear) begin
            check("error_one_cycle", 64'(file_error), 64'(0));
            chk_clear = 1'b0;
         end
         if (file_active) act_len++;
         else if (prev_act) begin
            if (exp_q.size() == 0) begin
               check("unexpected_response", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("active_len", 64'(act_len), 64'(2));
               check("error", 64'(file_error), 64'(e.err));
               check("read_data", 64'(file_read_data), 64'(e.rdata));
               check("empty", 64'(file_empty), 64'(e.empty));
               check("full", 64'(file_full), 64'(e.full));
            end
            chk_clear = 1'b1;
            act_len = 0;
         end
         prev_act = file_active;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_active", 64'(file_active), 64'(0));
      check("rst_error", 64'(file_error), 64'(0));
      check("rst_rdata", 64'(file_read_data), 64'(0));
      check("rst_empty", 64'(file_empty), 64'(4'hF));
      check("rst_full", 64'(file_full), 64'(0));
      @(negedge clk);

      issue(0, 1, 8'd2, 32'hDEADBEEF, 0);
      issue(1, 0, 8'd2, 32'h0, 0);

      for (int i = 0; i < 16; i++) issue(0, 1, 8'd0, 32'(i), 0);
      issue(0, 1, 8'd0, 32'h1234_5678, 0);
      for (int i = 0; i < 16; i++) issue(1, 0, 8'd0, 32'h0, 0);

      issue(1, 0, 8'd1, 32'h0, 0);
      issue(1, 0, 8'd7, 32'h0, 0);
      issue(1, 1, 8'd0, 32'h55AA, 0);

      issue(0, 1, 8'd1, 32'hA5A5_0001, 0);
      issue(1, 0, 8'd1, 32'h0, 1);
      issue(1, 0, 8'd1, 32'h0, 0);

      for (int n = 0; n < 300; n++) begin
         int   k;
         logic [7:0] num;
         num = ($urandom_range(0, 99) < 5) ? 8'($urandom_range(NF, 255)) : 8'($urandom_range(0, NF - 1));
         k = $urandom_range(0, 19);
         issue(k >= 11, k < 11 || k == 0, num, $urandom, $urandom_range(0, 9) == 0);
      end

      file_write = 1'b1;
      file_num = 8'd3;
      file_write_data = 32'hCAFE_0003;
      @(negedge clk);
      file_write = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("midreset_active", 64'(file_active), 64'(0));
      for (int f = 0; f < NF; f++) mq[f].delete();
      m_rdata = '0;
      @(negedge clk);
      check("midreset_empty", 64'(file_empty), 64'(4'hF));
      check("midreset_full", 64'(file_full), 64'(0));
      check("midreset_rdata", 64'(file_read_data), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      issue(0, 1, 8'd3, 32'h0BAD_F00D, 0);
      issue(1, 0, 8'd3, 32'h0, 0);
      issue(1, 0, 8'd3, 32'h0, 0);

      repeat (3) @(negedge clk);
      check("pending_responses", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dsp_file_responder.md
DSP_FILE_RESPONDER -- requirements
Module: dsp_file_responder

Interface
REQ-001 SHALL have parameter dw, default 32, data word width.
REQ-002 SHALL have parameter NUM_FILES, default 4, number of independent files.
REQ-003 SHALL have parameter DEPTH, default 16, words per file; power of two, >= 2.
REQ-004 SHALL have port wb_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port wb_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port file_num  input  8  file selector, sampled with the request.
REQ-007 SHALL have port file_write  input  1  one-cycle write request strobe.
REQ-008 SHALL have port file_read  input  1  one-cycle read request strobe.
REQ-009 SHALL have port file_write_data  input  dw  write word, sampled with file_write.
REQ-010 SHALL have port file_read_data  output  dw  read word, valid from the cycle file_active falls.
REQ-011 SHALL have port file_active  output  1  high while a request is being serviced.
REQ-012 SHALL have port file_error  output  1  one-cycle pulse coincident with file_active falling on a failed request.
REQ-013 SHALL have port file_empty  output  NUM_FILES  per-file empty flags.
REQ-014 SHALL have port file_full  output  NUM_FILES  per-file full flags.

Function
REQ-015 SHALL hold each file as an independent circular FIFO with its own read pointer, write pointer and count; the count is log2(DEPTH)+1 bits wide.
REQ-016 SHALL use a state machine IDLE -> ACCESS -> RESP -> IDLE; every transition takes exactly one cycle.
REQ-017 SHALL sample a request only in IDLE, on a cycle where file_read or file_write is high; file_num and file_write_data SHALL be captured in the same cycle.
REQ-018 SHALL drive file_active high in ACCESS and RESP, i.e. for exactly 2 cycles, starting the cycle after the request.
REQ-019 SHALL perform the FIFO update (push or pop, pointer and count change) at the end of ACCESS.
REQ-020 SHALL load file_read_data at the end of ACCESS on a successful read and hold it until the next successful read.
REQ-021 SHALL ignore strobes received while not in IDLE; they are not queued.
REQ-022 SHALL treat a request as failed when any of these holds: file_num >= NUM_FILES; file_read and file_write are both high; write to a full file; read from an empty file.
REQ-023 On a failed request, SHALL leave all FIFO state unchanged, keep file_read_data unchanged, still run the full ACCESS/RESP sequence, and pulse file_error in the cycle after RESP.
REQ-024 SHALL wrap pointers modulo DEPTH; file_full[n] SHALL be high iff count==DEPTH, and file_empty[n] SHALL be high iff count==0.
REQ-025 SHALL update file_full and file_empty registered, in the same cycle as the count changes.

Reset
REQ-026 On wb_rst high, SHALL immediately force: state=IDLE, file_active=0, file_error=0, file_read_data=0, all pointers and counts=0, file_empty=all ones, file_full=all zeros.
REQ-027 A reset asserted mid-request SHALL abort that request with no FIFO update; storage contents need not be cleared.
REQ-028 After wb_rst falls, SHALL accept a request on the first rising edge.

Verification
REQ-029 Write 0xDEADBEEF to file 2, then read file 2 -> file_active high 2 cycles for each request; file_read_data=0xDEADBEEF when file_active falls; file_empty[2] returns to 1.
REQ-030 Write 16 words (0..15) to file 0, then attempt a 17th write -> file_full[0]=1 after the 16th; the 17th write gives file_error pulse and count stays 16; 16 reads return 0..15 in order, exercising pointer wrap.
REQ-031 Read empty file 1; request file_num=7; assert file_read and file_write together -> each gives file_error=1 one cycle, file_read_data unchanged, all flags unchanged.
REQ-032 Pulse file_write during ACCESS of a prior read -> second strobe ignored; count of the target file unchanged.
REQ-033 Assert wb_rst during ACCESS of a write to file 3 -> file_active=0 asynchronously; file_empty[3]=1 after reset; a following request is serviced normally.
